// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: shadow pipe of in-flight writes, load-use stall and EX forward select.
// Optional HAZ_STATS_EN macro adds saturating stall and forward counters.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int DEPTH    = 4,
    parameter int LOAD_LAT = 3,
    parameter int NSRC     = 2,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_iss_valid,
    input  logic                 i_iss_wen,
    input  logic                 i_iss_load,
    input  logic [AW-1:0]        i_iss_wa,
    input  logic [NSRC*AW-1:0]   i_iss_ra,
    input  logic [NSRC-1:0]      i_iss_rused,
    input  logic                 i_flush,
    input  logic                 i_hold,
    output logic                 o_stall,
    output logic [NSRC*SW-1:0]   o_fwd_sel_e
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_fwd_cnt
`endif
);

    logic [DEPTH:1]      r_v;
    logic [DEPTH:1]      r_wen;
    logic [DEPTH:1]      r_load;
    logic [AW-1:0]       r_wa [1:DEPTH];
    logic [NSRC*SW-1:0]  r_fwd;

    logic [DEPTH:1]      w_match [NSRC];
    logic [NSRC-1:0]     w_haz;
    logic [NSRC*SW-1:0]  w_fwd;
    logic                w_anyHaz;
    logic                w_hazStall;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                w_match[i][k] = i_iss_rused[i] && r_v[k] && r_wen[k] &&
                                (r_wa[k] == i_iss_ra[i*AW +: AW]) &&
                                (i_iss_ra[i*AW +: AW] != '0);
            end
        end
    end

    // Scan oldest to youngest so the youngest (smallest k) match overwrites the rest.
    always_comb begin
        w_haz = '0;
        w_fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (w_match[i][k]) begin
                    w_haz[i] = r_load[k] ? (k < LOAD_LAT) : (k < 1);
                    w_fwd[i*SW +: SW] = (k < DEPTH) ? SW'(k + 1) : '0;
                end
            end
        end
    end

    assign w_anyHaz   = |w_haz;
    assign w_hazStall = i_iss_valid && !i_flush && w_anyHaz;
    assign o_stall    = w_hazStall || i_hold;
    assign o_fwd_sel_e = r_fwd;

    // Shadow pipe advances unless memory back-pressure freezes it; stalls inject a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v    <= '0;
            r_wen  <= '0;
            r_load <= '0;
            r_fwd  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_wa[k] <= '0;
            end
        end else if (!i_hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_v[k]    <= r_v[k-1];
                r_wen[k]  <= r_wen[k-1];
                r_load[k] <= r_load[k-1];
                r_wa[k]   <= r_wa[k-1];
            end
            r_v[1]    <= i_iss_valid && !i_flush && !w_anyHaz;
            r_wen[1]  <= i_iss_wen;
            r_load[1] <= i_iss_load;
            r_wa[1]   <= i_iss_wa;
            r_fwd     <= w_hazStall ? '0 : w_fwd;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_fwdCnt;
    logic [2:0]  w_fwdNz;

    always_comb begin
        w_fwdNz = '0;
        if (!w_hazStall) begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_fwd[i*SW +: SW] != '0) begin
                    w_fwdNz = w_fwdNz + 3'd1;
                end
            end
        end
    end

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stallCnt <= '0;
            r_fwdCnt   <= '0;
        end else if (!i_hold) begin
            if (w_hazStall && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (r_fwdCnt > (32'hFFFF_FFFF - 32'(w_fwdNz))) begin
                r_fwdCnt <= 32'hFFFF_FFFF;
            end else begin
                r_fwdCnt <= r_fwdCnt + 32'(w_fwdNz);
            end
        end
    end

    assign o_stall_cnt = r_stallCnt;
    assign o_fwd_cnt   = r_fwdCnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=4, LOAD_LAT=3, NSRC=2).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issValid = 1'b0;
    logic        issWen = 1'b0;
    logic        issLoad = 1'b0;
    logic [4:0]  issWa = '0;
    logic [9:0]  issRa = '0;
    logic [1:0]  issRused = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        stall;
    logic [5:0]  fwdSel;
`ifdef HAZ_STATS_EN
    logic [31:0] stallCnt;
    logic [31:0] fwdCnt;
`endif

    int checks = 0;
    int failures = 0;

    hazard_scoreboard #(.AW(5), .DEPTH(4), .LOAD_LAT(3), .NSRC(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_iss_valid (issValid),
        .i_iss_wen   (issWen),
        .i_iss_load  (issLoad),
        .i_iss_wa    (issWa),
        .i_iss_ra    (issRa),
        .i_iss_rused (issRused),
        .i_flush     (flush),
        .i_hold      (hold),
        .o_stall     (stall),
        .o_fwd_sel_e (fwdSel)
`ifdef HAZ_STATS_EN
        ,
        .o_stall_cnt (stallCnt),
        .o_fwd_cnt   (fwdCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic wen, input logic ld, input logic [4:0] wa,
                                 input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] used);
        issValid = v;
        issWen   = wen;
        issLoad  = ld;
        issWa    = wa;
        issRa    = {ra1, ra0};
        issRused = used;
    endtask

    task automatic drain();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        flush = 0;
        hold  = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL reset_fwd: got %0h expected 00", fwdSel); end
        applyStimulus(1, 0, 0, 0, 5'd3, 5'd4, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_entries: got %0b expected 0", stall); end
        tick();
    endtask

    task automatic test_back_to_back();
        drain();
        applyStimulus(1, 1, 0, 5'd3, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 1, 0, 5'd8, 5'd3, 5'd4, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_stall: got %0b expected 0", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h02) begin failures++; $display("[TB] FAIL alu_fwd: got %0h expected 02", fwdSel); end
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        hold = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("[TB] FAIL hold_stall: got %0b expected 1", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h02) begin failures++; $display("[TB] FAIL hold_fwd_keep: got %0h expected 02", fwdSel); end
        hold = 0;
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL fwd_after_hold: got %0h expected 00", fwdSel); end
    endtask

    task automatic test_load_use();
        drain();
        applyStimulus(1, 1, 1, 5'd5, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 1, 0, 5'd10, 5'd1, 5'd5, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall1: got %0b expected 1", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL ld_fwd_bubble: got %0h expected 00", fwdSel); end
        checks++;
        if (stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall2: got %0b expected 1", stall); end
        tick();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL ld_release: got %0b expected 0", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h20) begin failures++; $display("[TB] FAIL ld_fwd: got %0h expected 20", fwdSel); end
    endtask

    task automatic test_zero_and_unused();
        drain();
        applyStimulus(1, 1, 1, 5'd0, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 2'b11);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL r0_stall: got %0b expected 0", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL r0_fwd: got %0h expected 00", fwdSel); end
        drain();
        applyStimulus(1, 1, 1, 5'd6, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 0, 0, 0, 5'd6, 5'd6, 2'b00);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL unused_stall: got %0b expected 0", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL unused_fwd: got %0h expected 00", fwdSel); end
    endtask

    task automatic test_youngest();
        drain();
        applyStimulus(1, 1, 0, 5'd7, 0, 0, 2'b00);
        tick();
        tick();
        applyStimulus(1, 0, 0, 0, 5'd7, 5'd0, 2'b01);
        tick();
        checks++;
        if (fwdSel !== 6'h02) begin failures++; $display("[TB] FAIL youngest_fwd: got %0h expected 02", fwdSel); end
        drain();
        applyStimulus(1, 1, 0, 5'd7, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        applyStimulus(1, 0, 0, 0, 5'd7, 5'd0, 2'b01);
        tick();
        checks++;
        if (fwdSel !== 6'h04) begin failures++; $display("[TB] FAIL e3_fwd: got %0h expected 04", fwdSel); end
        drain();
        applyStimulus(1, 1, 0, 5'd7, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
        applyStimulus(1, 0, 0, 0, 5'd7, 5'd0, 2'b01);
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL retire_fwd: got %0h expected 00", fwdSel); end
    endtask

    task automatic test_hold_flush();
        int stallCycles;
        drain();
        applyStimulus(1, 1, 1, 5'd5, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 1, 0, 5'd10, 5'd1, 5'd5, 2'b10);
        hold = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1) begin failures++; $display("[TB] FAIL hold_cycle%0d: got %0b expected 1", c, stall); end
            tick();
        end
        hold = 0;
        stallCycles = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (stall !== 1'b1) break;
            stallCycles++;
            tick();
        end
        checks++;
        if (stallCycles != 2) begin failures++; $display("[TB] FAIL hold_remaining: got %0d expected 2", stallCycles); end
        tick();
        checks++;
        if (fwdSel !== 6'h20) begin failures++; $display("[TB] FAIL hold_ld_fwd: got %0h expected 20", fwdSel); end

        drain();
        applyStimulus(1, 1, 1, 5'd5, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 1, 0, 5'd9, 5'd1, 5'd5, 2'b10);
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall); end
        tick();
        flush = 0;
        checks++;
        if (fwdSel !== 6'h10) begin failures++; $display("[TB] FAIL flush_fwd: got %0h expected 10", fwdSel); end
        applyStimulus(1, 0, 0, 0, 5'd9, 5'd0, 2'b01);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_bubble_stall: got %0b expected 0", stall); end
        tick();
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL flush_bubble_fwd: got %0h expected 00", fwdSel); end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        applyStimulus(1, 1, 1, 5'd5, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 0, 0, 0, 5'd5, 5'd0, 2'b01);
        hold = 1;
        tick();
        rst  = 1;
        hold = 0;
        tick();
        rst = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stall: got %0b expected 0", stall); end
        checks++;
        if (fwdSel !== 6'h00) begin failures++; $display("[TB] FAIL rst_mid_fwd: got %0h expected 00", fwdSel); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_and_unused();
        test_youngest();
        test_hold_flush();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the RISC pipeline.
- Tracks every in-flight register write in a shadow shift register, one entry per post-decode stage (E[1]=EX … E[DEPTH]=WB).
- Generalises the fixed EX/M1/M2/WB hazard logic to any pipeline depth, any load latency and any number of source operands.
- Adds a memory back-pressure hold and a registered per-operand forward select for EX.

Parameters:
AW, 5, register address width
DEPTH, 4, number of post-decode stages tracked (EX..WB); legal range 2..8
LOAD_LAT, 3, smallest entry index at which a load result can be forwarded; legal range 1..DEPTH
NSRC, 2, source operands per instruction; legal range 1..4
SW, $clog2(DEPTH+1), forward-select width (derived, do not override)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ISS_VALID  in  1  decode holds a valid instruction
ISS_WEN  in  1  decode instruction writes a register
ISS_LOAD  in  1  decode instruction is a load
ISS_WA  in  AW  decode destination register
ISS_RA  in  NSRC*AW  decode source registers; operand i is at [i*AW +: AW]
ISS_RUSED  in  NSRC  per-source used flag
FLUSH  in  1  squash the decode instruction (taken branch/jump); it enters E[1] as a bubble
HOLD  in  1  memory back-pressure; freezes the whole shadow pipe
STALL  out  1  combinational; decode and fetch must hold
FWD_SEL_E  out  NSRC*SW  registered; per-operand EX source. 0 = register-file value; k = result of stage k (2..DEPTH)

Behaviour:
- Entry E[k] holds {v, wen, load, wa}.
- Reset (RST=1 at a clock edge):
  - all entries cleared to v=0;
  - FWD_SEL_E=0.
  - STALL then reads 0, since no entries are valid.
- Match for source i:
  - Condition: ISS_RUSED[i] && E[k].v && E[k].wen && E[k].wa==ISS_RA[i] && ISS_RA[i]!=0.
  - Only the youngest match (smallest k) counts.
  - Register 0 never matches.
- Ready index per entry: rdy = load ? LOAD_LAT : 1.
- Hazard for source i: a youngest match exists with k < rdy.
- STALL = ISS_VALID && !FLUSH && (any source hazard) || HOLD.
- Forward value for source i:
  - if the youngest match has k < DEPTH: k+1 (the producer's stage when the consumer is in EX);
  - if the youngest match has k == DEPTH, or there is no match: 0.
  - Integration requirement: the register file is write-first, so a value written in WB is visible to decode in the same cycle.
- Clock edge, HOLD=1:
  - no entry changes;
  - FWD_SEL_E holds.
  - HOLD dominates STALL, FLUSH and ISS_VALID.
- Clock edge, HOLD=0:
  - E[k+1] <= E[k] for k=1..DEPTH-1; E[DEPTH] retires.
  - E[1] <= {ISS_VALID && !FLUSH && !hazard, ISS_WEN, ISS_LOAD, ISS_WA}.
  - On a hazard stall, E[1] is a bubble (v=0) and FWD_SEL_E <= 0.
  - Otherwise FWD_SEL_E <= the forward values.
- The stall latency is exactly rdy-k cycles. Entries advance during a stall, so the hazard self-clears.
- Simultaneous FLUSH and hazard: FLUSH wins. No stall; a bubble is inserted.
- RST asserted mid-stall or mid-HOLD: all entries are discarded and STALL drops on the following cycle.
- No combinational path from FWD_SEL_E to STALL.

Optional Feature:
HAZ_STATS_EN
- Defined: adds outputs STALL_CNT[31:0] and FWD_CNT[31:0].
  - Both are saturating counters, cleared by RST.
  - STALL_CNT increments on each edge where STALL=1 && HOLD=0.
  - FWD_CNT increments once per edge for each nonzero operand field loaded into FWD_SEL_E.
- Undefined: the ports and the counters are absent; all other behaviour is identical.

Test Plan:
All cases use DEPTH=4, LOAD_LAT=3, NSRC=2.
1. Reset: hold RST 2 cycles, then idle -> STALL=0, FWD_SEL_E=0, all entries invalid.
2. ALU back-to-back: issue ADD r3 (wen), next cycle issue SUB using r3 as source 0 -> STALL=0; after the edge, FWD_SEL_E[0]=2, FWD_SEL_E[1]=0.
3. Load-use: issue LD r5, then an instruction using r5 as source 1 -> STALL=1 for exactly 2 cycles; on release, FWD_SEL_E[1]=4.
4. Register 0 and unused operand: producer writes r0, consumer reads r0; separately, a consumer with a matching register but ISS_RUSED=0 -> STALL=0, FWD_SEL_E=0 in both cases.
5. Youngest wins / retire: ADD r7, ADD r7, consumer of r7 -> FWD_SEL_E=2. With 3 NOPs between producer and consumer -> FWD_SEL_E=0.
6. HOLD and FLUSH: during a load-use stall, assert HOLD for 3 cycles -> entries frozen and STALL=1 throughout; after release, 2 remaining stall cycles. FLUSH together with a hazard -> STALL=0, E[1].v=0.
